// File: rtl/fetch_unit_if.sv
// ROM read/ready channel plus decode-side valid/accept channel of the fetch unit.
// master: the fetch unit (drives ROM request and instruction head).
// slave: the surroundings (ROM model, decode stage, redirect source).
interface fetch_unit_if #(
  parameter int size_addr = 8
);
  logic                 mem_read;
  logic [size_addr-1:0] mem_address;
  logic                 mem_ready;
  logic [15:0]          mem_data;
  logic                 jump;
  logic [size_addr-1:0] jump_addr;
  logic                 inst_valid;
  logic [15:0]          inst_data;
  logic [size_addr-1:0] inst_pc;
  logic                 inst_accept;

  modport master (
    output mem_read, mem_address, inst_valid, inst_data, inst_pc,
    input  mem_ready, mem_data, jump, jump_addr, inst_accept
  );

  modport slave (
    input  mem_read, mem_address, inst_valid, inst_data, inst_pc,
    output mem_ready, mem_data, jump, jump_addr, inst_accept
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential ROM reads, buffers words in a small FIFO, redirects on jump.
// Latency: request on 1st enabled edge, ROM data on 2nd, word visible at the FIFO head after the 3rd.
// Backpressure: requests stop while buffered + in-flight words could reach depth; FETCH_PERF_EN adds counters.
module fetch_unit #(
  parameter int                   size_addr  = 8,
  parameter int                   depth      = 4,
  parameter logic [size_addr-1:0] reset_addr = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]  fetch_count,
  output logic [15:0]  flush_count
`endif
);

  localparam int ptr_w = (depth > 1) ? $clog2(depth) : 1;
  localparam int cnt_w = $clog2(depth) + 1;
  localparam int sum_w = cnt_w + 1;

  typedef struct packed {
    logic [15:0]          data;
    logic [size_addr-1:0] pc;
  } entry_t;

  logic                 req;
  logic [size_addr-1:0] addr;
  logic [size_addr-1:0] pc;
  logic [size_addr-1:0] resp_addr;
  logic                 discard;
  logic [ptr_w-1:0]     rd_ptr;
  logic [ptr_w-1:0]     wr_ptr;
  logic [cnt_w-1:0]     count;
  entry_t               fifo_mem [depth];

  logic                 issue;
  logic                 push;
  logic                 pop;
  logic [sum_w-1:0]     used;
  entry_t               head;

  // Credit check counts buffered words plus both possible in-flight responses,
  // ignoring a same-cycle pop so the FIFO can never be overrun.
  always_comb begin
    used  = sum_w'(count) + sum_w'(req) + sum_w'(bus.mem_ready);
    issue = enable && !bus.jump && (used < sum_w'(depth));
    push  = bus.mem_ready && !discard && !bus.jump;
    pop   = (count != '0) && bus.inst_accept && !bus.jump;
    head  = fifo_mem[rd_ptr];
  end

  // Request side: registered read strobe, address, program counter and redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req  <= 1'b0;
      addr <= '0;
      pc   <= reset_addr;
    end else begin
      req <= issue;
      if (issue) begin
        addr <= pc;
      end
      if (bus.jump) begin
        pc <= bus.jump_addr;
      end else if (issue) begin
        pc <= pc + size_addr'(1);
      end
    end
  end

  // Response tagging and post-redirect drop of the one response still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_addr <= '0;
      discard   <= 1'b0;
    end else begin
      if (req) begin
        resp_addr <= addr;
      end
      discard <= bus.jump && req;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.jump) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ptr_w'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_w'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + cnt_w'(1);
        2'b01:   count <= count - cnt_w'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are only visible through the occupancy-gated head.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{data: bus.mem_data, pc: resp_addr};
    end
  end

`ifdef FETCH_PERF_EN
  // Performance counters: accepted pushes and redirects, both wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (push) begin
        fetch_count <= fetch_count + 16'd1;
      end
      if (bus.jump) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`endif

  assign bus.mem_read    = req;
  assign bus.mem_address = addr;
  assign bus.inst_valid  = (count != '0);
  assign bus.inst_data   = (count != '0) ? head.data : 16'h0000;
  assign bus.inst_pc     = (count != '0) ? head.pc : '0;

  // The credit rule must keep every push landing in a free slot.
  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count == cnt_w'(depth))));

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Initiator side of the ROM read/ready interface: generates read requests at consecutive addresses and collects the 16-bit words returned.
- Buffers returned words in a small FIFO and hands them to the decode stage with a valid/accept handshake.
- Supports a redirect (jump) that flushes buffered words and discards in-flight responses.
- Sits between the program ROM and the CPU decode/control stage.

Parameters:
size_addr, 8, width of ROM address and program counter
depth, 4, instruction FIFO entries (power of 2, >= 2)
reset_addr, 0, first fetch address after reset

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  allow new requests to be issued
mem_read  output  1  ROM read request (registered)
mem_address  output  size_addr  ROM address (registered; valid when mem_read=1)
mem_ready  input  1  ROM response strobe, high exactly one cycle after a mem_read cycle
mem_data  input  16  ROM read data, valid when mem_ready=1
jump  input  1  redirect request, single-cycle pulse
jump_addr  input  size_addr  redirect target
inst_valid  output  1  FIFO head is valid
inst_data  output  16  FIFO head word
inst_pc  output  size_addr  address of FIFO head word
inst_accept  input  1  consumer takes head when inst_valid=1

Behaviour:
- Reset (async, rst_n=0): mem_read=0, mem_address=0, pc=reset_addr, FIFO empty, inst_valid=0, inst_data=0, inst_pc=0, discard=0.
- ROM contract: data is sampled on the posedge where mem_read=1; mem_ready and mem_data are valid for the following cycle.
- Issue rule: at each posedge, mem_read <= issue.
  - issue = enable & !jump & (count + mem_read + mem_ready < depth).
  - This is a conservative credit check that ignores same-cycle pops.
- On issue: mem_address <= pc; pc <= pc+1 modulo 2^size_addr (wraps from 2^size_addr-1 to 0).
- resp_addr <= mem_address on every cycle with mem_read=1; it tags the next response.
- Write: on mem_ready=1 & !discard & !jump, push {mem_data, resp_addr}. The credit rule guarantees the FIFO is never full on a write; any overflow is a design error, checked by assertion.
- Pop: inst_valid & inst_accept & !jump advances the head. A simultaneous push and pop leaves count unchanged. Pop on empty is ignored.
- inst_valid = (count != 0); inst_data and inst_pc show the head entry, or 0 when empty.
- Jump (highest priority) at posedge:
  - FIFO cleared.
  - pc <= jump_addr.
  - mem_read <= 0.
  - A response arriving this cycle is dropped.
  - discard <= mem_read, so the response to a request presented during the jump cycle is dropped next cycle.
  - discard clears after one cycle.
  - Fetch resumes at jump_addr on the following posedge if enable=1.
- Latency: first enabled posedge E1 drives mem_read=1 with address reset_addr; mem_ready follows in cycle E2; inst_valid=1 from E3.
- Steady-state throughput is one word per cycle while consumption keeps count below depth-2.
- enable=0: no new requests; in-flight responses are still captured; the FIFO still drains.
- mem_address holds its last value while mem_read=0.

Optional Feature:
- Macro: FETCH_PERF_EN.
- With the macro defined:
  - Extra output fetch_count [15:0] counts words pushed into the FIFO.
  - Extra output flush_count [15:0] counts jumps.
  - Both reset to 0 and wrap at 16'hFFFF.
  - Discarded responses are not counted.
- Without the macro: neither port nor the counters exist; all other behaviour is identical.

Test Plan:
1. Reset then enable=1, inst_accept=1, ROM model preloaded mem[i]=16'h1000+i -> inst_valid from 3rd cycle, stream inst_data 1000,1001,1002... with inst_pc 0,1,2 on consecutive cycles.
2. inst_accept=0 for 10 cycles -> count saturates at depth=4, mem_read stays 0 after credit is exhausted, no overflow; release accept -> words 0..3 in order, then 4 onwards.
3. Pulse jump with jump_addr=8'h40 while mem_read=1 and mem_ready=1 -> FIFO empties, both in-flight words dropped, next inst_pc=8'h40, inst_data=1040.
4. reset_addr=8'hFE, size_addr=8 -> inst_pc sequence FE, FF, 00, 01.
5. enable dropped mid-stream -> outstanding responses still delivered, no new mem_read; re-enable resumes at the next sequential address with no gap or duplicate.
6. rst_n asserted asynchronously mid-stream (between edges) -> all outputs 0 immediately; after release, fetch restarts at reset_addr; with FETCH_PERF_EN, fetch_count=0 and it counts pushes only.
